// File: rtl/alu_exec_unit.sv
// rtl/alu_exec_unit.sv - multi-cycle ALU execute unit with bit-serial shifter
// Single-cycle add/sub/logic; shifts step one bit position per cycle.
module alu_exec_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       alu_sel,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  input  logic [4:0]       shamt,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             illegal
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state, state_next;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] acc_next;
  logic [CW-1:0]    cnt;
  logic [3:0]       op;
  logic [WIDTH-1:0] alu_res;
  logic             is_shift;
  logic             bad_op;
  logic [CW-1:0]    cnt_in;
  logic             accept;

  assign accept = (state == IDLE) && in_valid;

  // Decode; for shifts alu_res is b, which is the answer when the count is 0.
  always_comb begin
    alu_res  = '0;
    is_shift = 1'b0;
    bad_op   = 1'b0;
    cnt_in   = '0;
    case (alu_sel)
      4'b0000: alu_res = src_a + src_b;
      4'b0001: alu_res = src_a - src_b;
      4'b0010, 4'b0011: begin
        alu_res  = src_b;
        is_shift = 1'b1;
        cnt_in   = CW'(shamt);
      end
      4'b0100, 4'b0101, 4'b0110: begin
        alu_res  = src_b;
        is_shift = 1'b1;
        cnt_in   = src_a[CW-1:0];
      end
      4'b0111: alu_res = src_a & src_b;
      4'b1000: alu_res = src_a | src_b;
      4'b1001: alu_res = src_a ^ src_b;
      4'b1010: alu_res = ~(src_a ^ src_b);
      default: bad_op = 1'b1;
    endcase
  end

  always_comb begin
    acc_next = '0;
    case (op)
      4'b0010, 4'b0100: acc_next = {acc[WIDTH-2:0], 1'b0};
      4'b0110:          acc_next = {acc[WIDTH-1], acc[WIDTH-1:1]};
      default:          acc_next = {1'b0, acc[WIDTH-1:1]};
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (in_valid) state_next = (is_shift && cnt_in != '0) ? SHIFT : DONE;
      SHIFT:   if (cnt == CW'(1)) state_next = DONE;
      DONE:    if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state == IDLE);
    out_valid = (state == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc     <= '0;
      cnt     <= '0;
      op      <= '0;
      result  <= '0;
      zero    <= 1'b0;
      illegal <= 1'b0;
    end else if (accept) begin
      op <= alu_sel;
      if (is_shift && cnt_in != '0) begin
        acc <= src_b;
        cnt <= cnt_in;
      end else begin
        result  <= alu_res;
        zero    <= (alu_res == '0);
        illegal <= bad_op;
      end
    end else if (state == SHIFT) begin
      acc <= acc_next;
      cnt <= cnt - CW'(1);
      if (cnt == CW'(1)) begin
        result  <= acc_next;
        zero    <= (acc_next == '0);
        illegal <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_alu_exec_unit.sv
// tb/tb_alu_exec_unit.sv - directed and randomized checks of alu_exec_unit
// against a behavioural operation/latency model.
module tb_alu_exec_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [3:0]  alu_sel = 4'b0;
  logic [31:0] src_a = '0;
  logic [31:0] src_b = '0;
  logic [4:0]  shamt = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] result;
  logic        zero;
  logic        illegal;

  int checks = 0;
  int errors = 0;

  alu_exec_unit #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .alu_sel(alu_sel), .src_a(src_a), .src_b(src_b), .shamt(shamt),
    .out_valid(out_valid), .out_ready(out_ready), .result(result),
    .zero(zero), .illegal(illegal)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Expected result, illegal flag and accept-to-out_valid latency in cycles.
  function automatic void model(input logic [3:0] sel, input logic [31:0] a, input logic [31:0] b,
                                input logic [4:0] sh, output logic [31:0] r, output logic ill,
                                output int lat);
    logic signed [31:0] sb;
    sb  = b;
    r   = '0;
    ill = 1'b0;
    lat = 1;
    if ($isunknown(sel)) ill = 1'b1;
    else case (sel)
      4'd0:  r = a + b;
      4'd1:  r = a - b;
      4'd2:  begin r = b << sh;       lat = 1 + int'(sh); end
      4'd3:  begin r = b >> sh;       lat = 1 + int'(sh); end
      4'd4:  begin r = b << a[4:0];   lat = 1 + int'(a[4:0]); end
      4'd5:  begin r = b >> a[4:0];   lat = 1 + int'(a[4:0]); end
      4'd6:  begin r = sb >>> a[4:0]; lat = 1 + int'(a[4:0]); end
      4'd7:  r = a & b;
      4'd8:  r = a | b;
      4'd9:  r = a ^ b;
      4'd10: r = ~(a ^ b);
      default: ill = 1'b1;
    endcase
  endfunction

  task automatic run_op(input logic [3:0] sel, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] sh, input int hold, input bit poke);
    logic [31:0] er;
    logic        ei;
    int          el;
    int          lat;
    model(sel, a, b, sh, er, ei, el);
    check("in_ready_idle", in_ready, 1);
    in_valid = 1'b1;
    alu_sel  = sel;
    src_a    = a;
    src_b    = b;
    shamt    = sh;
    @(posedge clk); #1;
    in_valid = 1'b0;
    src_a    = $urandom;
    src_b    = $urandom;
    shamt    = 5'($urandom);
    lat = 1;
    while (!out_valid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    check("latency", lat, el);
    check("result", result, er);
    check("zero", zero, (er == 0));
    check("illegal", illegal, ei);
    for (int i = 0; i < hold; i++) begin
      if (poke) begin
        in_valid = 1'b1;
        alu_sel  = 4'd0;
        src_a    = 32'h1;
        src_b    = 32'h1;
      end
      @(posedge clk); #1;
      check("hold_result", result, er);
      check("hold_valid", out_valid, 1);
      check("hold_in_ready", in_ready, 0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("done_valid_low", out_valid, 0);
    check("done_in_ready", in_ready, 1);
    if (poke) begin
      @(posedge clk); #1;
      check("poke_ignored", out_valid, 0);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [3:0] zsel;
    zsel = 4'bzzzz;
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_result", result, 0);
    check("rst_zero", zero, 0);
    check("rst_illegal", illegal, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    run_op(4'd0, 32'h7FFFFFFF, 32'h00000001, 5'd0, 0, 1'b0);
    run_op(4'd1, 32'h00001234, 32'h00001234, 5'd0, 0, 1'b0);
    run_op(4'd6, 32'd4, 32'h80000000, 5'd0, 0, 1'b0);
    run_op(4'd5, 32'd4, 32'h80000000, 5'd0, 0, 1'b0);
    run_op(4'd2, 32'd0, 32'h00000001, 5'd31, 0, 1'b0);
    run_op(4'd2, 32'd0, 32'h000000A5, 5'd0, 0, 1'b0);
    run_op(4'd10, 32'hF0F0F0F0, 32'h0F0F0F0F, 5'd0, 3, 1'b1);
    run_op(4'b1111, 32'h5, 32'h6, 5'd0, 0, 1'b0);
    run_op(zsel, 32'h5, 32'h6, 5'd0, 0, 1'b0);
    run_op(4'd7, 32'hFF00FF00, 32'h0FF00FF0, 5'd0, 0, 1'b0);

    // Abort a 10-step LSVL in its third cycle.
    in_valid = 1'b1;
    alu_sel  = 4'd4;
    src_a    = 32'd10;
    src_b    = 32'h00000003;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("abort_out_valid", out_valid, 0);
    check("abort_in_ready", in_ready, 1);
    check("abort_result", result, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    run_op(4'd0, 32'd2, 32'd3, 5'd0, 0, 1'b0);

    for (int n = 0; n < 60; n++) begin
      logic [31:0] ra;
      logic [31:0] rb;
      ra = $urandom;
      rb = $urandom;
      if (n % 7 == 0) rb = ra;
      run_op(4'($urandom_range(0, 15)), ra, rb, 5'($urandom), $urandom_range(0, 2), 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_exec_unit.md
# alu_exec_unit

Multi-cycle execution unit that consumes the 4-bit `ALUSel` operation code produced by the ALU decoder and executes the selected operation on two operands. Add/sub/logic complete in one cycle; shifts run iteratively, one bit position per cycle, to avoid a full barrel shifter. It sits in the execute stage between the operand/decoder logic and writeback. Valid/ready handshakes on both sides let the control path stall while a shift is in flight.

## Interface
- `WIDTH`, 32: operand and result width. Shift count is the low `$clog2(WIDTH)` bits of its source; 5 bits at the default.
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `in_valid`  in  1  operation request.
- `in_ready`  out  1  unit can accept a request.
- `alu_sel`  in  4  operation code, encoding below.
- `src_a`  in  WIDTH  rs operand. Its low bits are the count for variable shifts.
- `src_b`  in  WIDTH  rt operand. Shifts operate on this value.
- `shamt`  in  5  immediate shift count for LSL/LSR.
- `out_valid`  out  1  result available.
- `out_ready`  in  1  consumer takes result.
- `result`  out  WIDTH  operation result.
- `zero`  out  1  result == 0.
- `illegal`  out  1  the completed request had an unsupported `alu_sel`.

## Operation
- `alu_sel` encoding:
  - 0000 ADD: a+b
  - 0001 SUB: a−b
  - 0010 LSL: b<<shamt
  - 0011 LSR: b>>shamt, logical
  - 0100 LSVL: b<<a[4:0]
  - 0101 LSVR: b>>a[4:0], logical
  - 0110 ASVR: b>>>a[4:0], arithmetic
  - 0111 AND
  - 1000 OR
  - 1001 XOR
  - 1010 XNOR
- Any other value, including X/Z, is illegal: `result`=0, `illegal`=1, `zero`=1.
- Arithmetic is modulo 2^WIDTH. There is no overflow or carry output.
- The FSM has three states:
  - IDLE: `in_ready`=1. On `in_valid`, capture `alu_sel`, operands and count.
    - Non-shift or illegal op: compute and go to DONE.
    - Shift with count 0: `result`=b, go to DONE.
    - Shift with count > 0: load the accumulator with b and the counter with the count, go to SHIFT.
  - SHIFT: each cycle, shift the accumulator one position (ASVR replicates the MSB) and decrement the counter. On the cycle the counter reaches 0, go to DONE.
  - DONE: `out_valid`=1. `result`, `zero` and `illegal` hold stable. On `out_ready`, go to IDLE.
- Inputs are ignored outside IDLE, because `in_ready`=0 in SHIFT and DONE.
- `zero` and `illegal` are registered together with `result`.

## Timing
- Reset values:
  - state IDLE
  - `in_ready`=1
  - `out_valid`=0
  - `result`=0
  - `zero`=0
  - `illegal`=0
  - internal counter and accumulator = 0
- Reset asserted mid-operation aborts immediately: state goes to IDLE and the in-flight result is discarded.
- Accept happens at edge T, where `in_valid`&`in_ready` is true.
  - Non-shift, illegal, or shift with count 0: `out_valid` rises at T+1.
  - Shift with count n: `out_valid` rises at T+1+n, so worst case is T+32.
- Completion happens at the edge where `out_valid`&`out_ready` is true. `out_valid` falls and `in_ready` rises the next cycle, so minimum throughput is one op per 2 cycles.
- No combinational path from `in_valid` to `out_valid`, or from `out_ready` to `in_ready`.
- `result` must not change while `out_valid`=1 and `out_ready`=0.

## Test plan
- ADD, a=0x7FFFFFFF, b=0x00000001 -> `result`=0x80000000, `zero`=0, `out_valid` 1 cycle after accept. Then SUB, a=b=0x1234 -> `result`=0, `zero`=1.
- ASVR, b=0x80000000, a=4 -> `result`=0xF8000000 at accept+5. LSVR with the same operands -> 0x08000000 at accept+5.
- LSL, b=1, shamt=31 -> 0x80000000 at accept+32. LSL, b=0xA5, shamt=0 -> 0xA5 at accept+1.
- Backpressure: hold `out_ready`=0 for 3 cycles after an XNOR of 0xF0F0F0F0 and 0x0F0F0F0F -> `result`=0x00000000 stable, `out_valid`=1, `in_ready`=0 throughout; a new `in_valid` during this window is ignored.
- Illegal: `alu_sel`=4'b1111, then 4'bzzzz -> `result`=0, `illegal`=1, `zero`=1 at accept+1. `illegal` clears on the next legal op.
- Reset: assert `rst_n`=0 during cycle 3 of a 10-cycle LSVL -> `out_valid`=0, `in_ready`=1, `result`=0 immediately. After release, an ADD 2+3 returns 5 normally.
